// File: rtl/alu_pkg.sv
// Shared types for the ALU command interface: opcodes, responder FSM states, response record.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        XOR = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } rsp_state_e;

    localparam int OPND_W    = 8;
    localparam int RES_W     = 16;
    // The response record is shared by every instance, so its tag field is
    // sized for the widest tag an instance may use; instances use the low bits.
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [RES_W-1:0]     result;
        opcode_e              op;
        logic [TAG_MAX_W-1:0] tag;
    } alu_rsp_t;

    localparam alu_rsp_t RSP_IDLE = '{result: '0, op: ADD, tag: '0};

    // Combinational reference ALU; operands are zero-extended to 16 bits.
    function automatic logic [RES_W-1:0] alu_calc(input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b,
                                                  input opcode_e           op);
        logic [RES_W-1:0] ax;
        logic [RES_W-1:0] bx;
        ax = {8'h00, a};
        bx = {8'h00, b};
        unique case (op)
            ADD:     return ax + bx;
            SUB:     return ax - bx;
            MUL:     return ax * bx;
            XOR:     return ax ^ bx;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add 8x8 multiplier, MUL_STEP multiplier bits retired per cycle.
// Latency: start edge loads operands, done pulses in the 8/MUL_STEP-th cycle after it.
// Backpressure: none; the caller must register product in the cycle done is high.
//  clk, rst    clock, async active-high reset
//  start       load a/b and begin a new product (abandons any product in flight)
//  a, b        operands, sampled only with start
//  done        single-cycle pulse, product valid in that cycle only
//  product     16-bit result, 0 whenever done is low
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int MUL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic              done,
    output logic [RES_W-1:0]  product
);

    localparam int ITERS = OPND_W / MUL_STEP;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    logic              running;
    logic [CNT_W-1:0]  cnt;
    logic [RES_W-1:0]  mcand;   // multiplicand, pre-shifted to the current bit weight
    logic [OPND_W-1:0] mplier;  // multiplier, consumed from the LSB end
    logic [RES_W-1:0]  acc;
    logic [RES_W-1:0]  partial;
    logic [RES_W-1:0]  sum;

    // Partial product for the MUL_STEP low multiplier bits of this iteration.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    assign sum     = acc + partial;
    assign done    = running && (cnt == LAST);
    // The final iteration's sum is the product; no extra register stage.
    assign product = done ? sum : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= {8'h00, a};
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc     <= sum;
            mcand   <= mcand << MUL_STEP;
            mplier  <= mplier >> MUL_STEP;
            cnt     <= cnt + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_responder.sv
// Request/response front end for the 8-bit ALU op set, returning a tagged 16-bit result.
// Latency: ADD/SUB/XOR 1 cycle accept-to-rsp_valid, MUL 1 + 8/MUL_STEP cycles.
// Backpressure: one op in flight; req_ready low in BUSY/RESP; response held until rsp_ready.
//  clk, rst                     clock, async active-high reset
//  req_valid/req_ready          request handshake (req_ready combinational from state)
//  req_a, req_b, req_op, req_tag request payload, captured on accept
//  rsp_valid/rsp_ready          response handshake
//  rsp_result, rsp_op, rsp_tag  registered response payload
//  ops_done                     completed response handshakes, wraps
module alu_responder
    import alu_pkg::*;
#(
    parameter int TAG_W    = 4,
    parameter int MUL_STEP = 1,
    parameter int COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OPND_W-1:0]  req_a,
    input  logic [OPND_W-1:0]  req_b,
    input  opcode_e            req_op,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RES_W-1:0]   rsp_result,
    output opcode_e            rsp_op,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [COUNT_W-1:0] ops_done
);

    if (!(MUL_STEP == 1 || MUL_STEP == 2 || MUL_STEP == 4 || MUL_STEP == 8)) begin : g_bad_step
        $error("alu_responder: MUL_STEP must be 1, 2, 4 or 8");
    end
    if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
        $error("alu_responder: TAG_W out of range");
    end

    rsp_state_e       state;
    rsp_state_e       next_state;
    logic             accept;
    logic             rsp_fire;
    logic             mul_start;
    logic             mul_done;
    logic [RES_W-1:0] mul_product;
    logic [TAG_W-1:0] cap_tag;
    alu_rsp_t         rsp_q;
    alu_rsp_t         rsp_d;

    assign accept    = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign mul_start = accept && (req_op == MUL);

    // Multiplier captures the operands itself on mul_start.
    alu_mul_seq #(
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (req_a),
        .b       (req_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = (req_op == MUL) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (mul_done) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_fire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Response payload: loaded by a single-cycle op on accept or by the
    // multiplier's done pulse, cleared back to the idle record on handshake so
    // the result reads 0 whenever no response is pending.
    always_comb begin
        rsp_d = rsp_q;
        if (rsp_fire) begin
            rsp_d = RSP_IDLE;
        end else if (accept && (req_op != MUL)) begin
            rsp_d.result             = alu_calc(req_a, req_b, req_op);
            rsp_d.op                 = req_op;
            rsp_d.tag                = '0;
            rsp_d.tag[TAG_W-1:0]     = req_tag;
        end else if ((state == BUSY) && mul_done) begin
            rsp_d.result             = mul_product;
            rsp_d.op                 = MUL;
            rsp_d.tag                = '0;
            rsp_d.tag[TAG_W-1:0]     = cap_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q     <= RSP_IDLE;
            rsp_valid <= 1'b0;
            cap_tag   <= '0;
            ops_done  <= '0;
        end else begin
            rsp_q     <= rsp_d;
            rsp_valid <= (next_state == RESP);
            if (accept) begin
                cap_tag <= req_tag;
            end
            if (rsp_fire) begin
                ops_done <= ops_done + COUNT_W'(1);
            end
        end
    end

    assign rsp_result = rsp_q.result;
    assign rsp_op     = rsp_q.op;
    assign rsp_tag    = rsp_q.tag[TAG_W-1:0];

    if (TAG_W < TAG_MAX_W) begin : g_tag_pad
        logic unused_tag_pad;
        assign unused_tag_pad = ^rsp_q.tag[TAG_MAX_W-1:TAG_W];
    end

endmodule

// File: tb/tb_alu_responder.sv
// Self-checking bench for alu_responder: directed scenarios plus randomized ops
// against a plain-arithmetic ALU model, with random response stalls.
// Runs a MUL_STEP=1 instance (main) and a MUL_STEP=4 instance (latency check).
module tb_alu_responder;
    import alu_pkg::*;

    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // MUL_STEP = 1 instance
    logic          req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0]    req_a, req_b;
    opcode_e       req_op, rsp_op;
    logic [TW-1:0] req_tag, rsp_tag;
    logic [15:0]   rsp_result, ops_done;

    // MUL_STEP = 4 instance
    logic          q_req_valid, q_req_ready, q_rsp_valid, q_rsp_ready;
    logic [7:0]    q_req_a, q_req_b;
    opcode_e       q_req_op, q_rsp_op;
    logic [TW-1:0] q_req_tag, q_rsp_tag;
    logic [15:0]   q_rsp_result, q_ops_done;

    alu_responder #(.TAG_W(TW), .MUL_STEP(1), .COUNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_tag(rsp_tag),
        .ops_done(ops_done)
    );

    alu_responder #(.TAG_W(TW), .MUL_STEP(4), .COUNT_W(16)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(q_req_valid), .req_ready(q_req_ready),
        .req_a(q_req_a), .req_b(q_req_b), .req_op(q_req_op), .req_tag(q_req_tag),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready),
        .rsp_result(q_rsp_result), .rsp_op(q_rsp_op), .rsp_tag(q_rsp_tag),
        .ops_done(q_ops_done)
    );

    int total = 0;
    int bad   = 0;
    int exp_ops = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    // Expected result straight from the arithmetic definition of each op.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input opcode_e op);
        int unsigned x;
        int unsigned y;
        x = a;
        y = b;
        case (op)
            ADD:     return 16'(x + y);
            SUB:     return 16'(x - y);
            MUL:     return 16'(x * y);
            default: return 16'(x ^ y);
        endcase
    endfunction

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the MUL_STEP=1 instance with up to
    // stall_max cycles of response backpressure.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input opcode_e op,
                         input logic [TW-1:0] tag, input int stall_max);
        logic [15:0] exp_r;
        int          n;
        int          lat;
        int          stalls;
        logic        busy_ok;
        logic        stable;
        exp_r   = model(a, b, op);
        busy_ok = 1'b1;
        stable  = 1'b1;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        rsp_ready = (stall_max == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", req_ready, 1'b1);
        tick();                                // accept edge
        req_valid = 1'b0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_tag = TW'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            if (stall_max != 0) rsp_ready = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        chk("latency", lat, (op == MUL) ? 9 : 1);
        if (op == MUL) chk("busy_ready", busy_ok, 1'b1);
        chk("result", rsp_result, exp_r);
        chk("tag", rsp_tag, tag);
        chk("op", rsp_op, op);
        chk("resp_ready", req_ready, 1'b0);
        stalls = (stall_max == 0) ? 0 : $urandom_range(0, stall_max);
        for (int s = 0; s < stalls; s++) begin
            rsp_ready = 1'b0;
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== exp_r || rsp_tag !== tag || req_ready !== 1'b0)
                stable = 1'b0;
        end
        if (stalls > 0) chk("stall_hold", stable, 1'b1);
        rsp_ready = 1'b1;
        tick();                                // response handshake edge
        exp_ops++;
        chk("ops_done", ops_done, 16'(exp_ops));
        chk("idle_valid", rsp_valid, 1'b0);
        chk("idle_result", rsp_result, 16'h0000);
        chk("idle_ready", req_ready, 1'b1);
    endtask

    initial begin
        int   lat;
        logic stable;

        rst = 1'b1;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_op = ADD; req_tag = '0; rsp_ready = 1'b0;
        q_req_valid = 1'b0; q_req_a = '0; q_req_b = '0; q_req_op = ADD; q_req_tag = '0; q_rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_result", rsp_result, 16'h0000);
        chk("rst_op", rsp_op, ADD);
        chk("rst_tag", rsp_tag, 4'h0);
        chk("rst_ops", ops_done, 16'h0000);
        rst = 1'b0;
        tick();

        // ADD with carry into bit 8
        do_op(8'hFF, 8'h01, ADD, 4'd3, 0);

        // SUB, including wrap below zero
        do_op(8'h05, 8'h03, SUB, 4'd4, 0);
        do_op(8'h00, 8'h01, SUB, 4'd5, 0);

        // MUL, largest operands, one bit per cycle
        do_op(8'hFF, 8'hFF, MUL, 4'd6, 0);

        // MUL on the four-bits-per-cycle instance
        q_req_a = 8'hFF; q_req_b = 8'hFF; q_req_op = MUL; q_req_tag = 4'd9;
        q_rsp_ready = 1'b1; q_req_valid = 1'b1;
        chk("q_ready", q_req_ready, 1'b1);
        tick();
        q_req_valid = 1'b0;
        lat = 1;
        while (!q_rsp_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("q_latency", lat, 3);
        chk("q_result", q_rsp_result, 16'hFE01);
        chk("q_tag", q_rsp_tag, 4'd9);
        tick();
        chk("q_ops_done", q_ops_done, 16'd1);

        // XOR held under backpressure with a second request waiting
        rsp_ready = 1'b0;
        req_a = 8'hA5; req_b = 8'h0F; req_op = XOR; req_tag = 4'd5; req_valid = 1'b1;
        chk("x_ready", req_ready, 1'b1);
        tick();
        req_a = 8'h10; req_b = 8'h20; req_op = ADD; req_tag = 4'd6;   // second request, held
        chk("x_valid", rsp_valid, 1'b1);
        chk("x_result", rsp_result, 16'h00AA);
        stable = 1'b1;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_result !== 16'h00AA || rsp_tag !== 4'd5 || req_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("x_stable", stable, 1'b1);
        rsp_ready = 1'b1;
        tick();
        exp_ops++;
        rsp_ready = 1'b0;
        chk("x_ops", ops_done, 16'(exp_ops));
        chk("x_idle", rsp_valid, 1'b0);
        chk("x2_ready", req_ready, 1'b1);
        tick();                                // second request accepted here
        req_valid = 1'b0;
        chk("x2_valid", rsp_valid, 1'b1);
        chk("x2_result", rsp_result, 16'h0030);
        chk("x2_tag", rsp_tag, 4'd6);
        rsp_ready = 1'b1;
        tick();
        exp_ops++;
        chk("x2_ops", ops_done, 16'(exp_ops));

        // Reset in the middle of a MUL
        req_a = 8'h12; req_b = 8'h34; req_op = MUL; req_tag = 4'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mr_ready", req_ready, 1'b1);
        chk("mr_valid", rsp_valid, 1'b0);
        chk("mr_result", rsp_result, 16'h0000);
        chk("mr_op", rsp_op, ADD);
        chk("mr_tag", rsp_tag, 4'h0);
        chk("mr_ops", ops_done, 16'h0000);
        exp_ops = 0;
        tick();
        rst = 1'b0;
        tick();
        do_op(8'h01, 8'h02, ADD, 4'd8, 0);

        // Randomized ops with random response stalls
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            do_op(8'($urandom), 8'($urandom), opcode_e'($urandom_range(0, 3)), TW'(i), 3);
        end
        chk("final_ops", ops_done, 16'd1001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
